// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    localparam int MAX_MEM_LATENCY = 15;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter, master = requesters + memory.
interface mem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_SIZE     = 32
);
    logic                   if_req;
    logic [ADDRESS_WIDTH:0] if_addr;
    logic                   if_gnt;
    logic                   if_valid;
    logic [DATA_SIZE-1:0]   if_rdata;

    logic                   ls_req;
    logic                   ls_we;
    logic [ADDRESS_WIDTH:0] ls_addr;
    logic [DATA_SIZE-1:0]   ls_wdata;
    logic                   ls_gnt;
    logic                   ls_valid;
    logic [DATA_SIZE-1:0]   ls_rdata;

    logic                   mem_en;
    logic                   mem_we;
    logic [ADDRESS_WIDTH:0] mem_addr;
    logic [DATA_SIZE-1:0]   mem_wdata;
    logic [DATA_SIZE-1:0]   mem_rdata;

    logic                   busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_picker.sv
// Combinational winner select between IF and LS.
// MEM_ARB_ROUND_ROBIN_EN: on contention pick the requester not granted last; otherwise LS wins.
module arb_picker
    import mem_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    ls_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  req_id_e last_winner,
`endif
    output logic    any_req,
    output req_id_e winner
);

    always_comb begin
        any_req = if_req | ls_req;
        winner  = REQ_IF;
        if (if_req && ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            winner = (last_winner == REQ_LS) ? REQ_IF : REQ_LS;
`else
            winner = REQ_LS;
`endif
        end else if (ls_req) begin
            winner = REQ_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and LS loads/stores onto one memory port with a fixed access latency.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of LS-first arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_SIZE     = 32,
    parameter int MEM_LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
    end

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    req_id_e                winner_q, winner_d;
    logic                   we_q, we_d;
    logic [ADDRESS_WIDTH:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
    logic [DATA_SIZE-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_SIZE-1:0]   ls_rdata_q, ls_rdata_d;
    logic                   if_gnt_q, if_gnt_d;
    logic                   ls_gnt_q, ls_gnt_d;
    logic                   any_req;
    req_id_e                pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_e                last_q, last_d;
`endif

    arb_picker u_picker (
        .if_req      (bus.if_req),
        .ls_req      (bus.ls_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_winner (last_q),
`endif
        .any_req     (any_req),
        .winner      (pick)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        winner_d   = winner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_gnt_d   = 1'b0;
        ls_gnt_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE, RESP: begin
                if (any_req) begin
                    // Latch the winner's request so later changes on its inputs are ignored.
                    state_d  = ACCESS;
                    cnt_d    = LAT_M1;
                    winner_d = pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d   = pick;
`endif
                    if (pick == REQ_LS) begin
                        we_d     = bus.ls_we;
                        addr_d   = bus.ls_addr;
                        wdata_d  = bus.ls_wdata;
                        ls_gnt_d = 1'b1;
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        wdata_d  = '0;
                        if_gnt_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (winner_q == REQ_IF) if_rdata_d = bus.mem_rdata;
                        else                    ls_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            winner_q   <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_gnt_q   <= 1'b0;
            ls_gnt_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= REQ_IF;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            winner_q   <= winner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_gnt_q   <= if_gnt_d;
            ls_gnt_q   <= ls_gnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    // Memory-side outputs decode straight from state so an async reset drops them at once.
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.ls_gnt    = ls_gnt_q;
    assign bus.if_valid  = (state_q == RESP) && (winner_q == REQ_IF);
    assign bus.ls_valid  = (state_q == RESP) && (winner_q == REQ_LS);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_SIZE(DW)) bus ();

    mem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_SIZE(DW), .MEM_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory environment: returns real data only in the final enable cycle, garbage before.
    logic [DW-1:0] env_mem [0:63];
    int            en_cnt = 0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            en_cnt <= en_cnt + 1;
            if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
        end else begin
            en_cnt <= 0;
        end
    end
    always_comb begin
        if (bus.mem_en && en_cnt == LAT - 1) bus.mem_rdata = env_mem[bus.mem_addr];
        else                                 bus.mem_rdata = 32'hBAD0_0000 | 32'(en_cnt);
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:63];
    logic [DW-1:0] ref_rd [0:1];
    int            last = 0;
    int            n_total = 0;
    int            n_pass = 0;
    int            n_txn = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst) chk("gnt_exclusive", {63'd0, bus.if_gnt & bus.ls_gnt}, 64'd0);
    end

    function automatic int pick(input logic i, input logic l);
        if (i && l) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (last == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        return l ? 1 : 0;
    endfunction

    task automatic idle_check();
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy",     bus.busy,     0);
        chk("idle_mem_en",   bus.mem_en,   0);
        chk("idle_if_gnt",   bus.if_gnt,   0);
        chk("idle_ls_gnt",   bus.ls_gnt,   0);
        chk("idle_if_valid", bus.if_valid, 0);
        chk("idle_ls_valid", bus.ls_valid, 0);
    endtask

    // Caller sets requests before a sampling edge; returns at the negedge of the response cycle.
    task automatic do_access(input bit keep, input bit pulse_ls);
        int            w;
        logic [AW:0]   a;
        logic          we;
        logic [DW-1:0] wd;
        w = pick(bus.if_req, bus.ls_req);
        if (w == 1) begin a = bus.ls_addr; we = bus.ls_we; wd = bus.ls_wdata; end
        else        begin a = bus.if_addr; we = 1'b0;      wd = '0;          end
        @(posedge clk);
        last = w;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            chk("acc_mem_en",   bus.mem_en,   1);
            chk("acc_mem_we",   bus.mem_we,   we);
            chk("acc_mem_addr", bus.mem_addr, a);
            if (we) chk("acc_mem_wdata", bus.mem_wdata, wd);
            chk("acc_if_gnt",   bus.if_gnt,   (k == 0 && w == 0));
            chk("acc_ls_gnt",   bus.ls_gnt,   (k == 0 && w == 1));
            chk("acc_busy",     bus.busy,     1);
            chk("acc_if_valid", bus.if_valid, 0);
            chk("acc_ls_valid", bus.ls_valid, 0);
            if (k == 0) begin
                if (!keep) begin
                    if (w == 1) begin
                        bus.ls_req = 1'b0; bus.ls_we = 1'($urandom);
                        bus.ls_addr = 6'($urandom); bus.ls_wdata = $urandom;
                    end else begin
                        bus.if_req = 1'b0; bus.if_addr = 6'($urandom);
                    end
                end
                if (pulse_ls) begin
                    bus.ls_req = 1'b1; bus.ls_we = 1'b1;
                    bus.ls_addr = 6'($urandom); bus.ls_wdata = $urandom;
                end
            end
            if (k == 1 && pulse_ls) bus.ls_req = 1'b0;
            @(posedge clk);
        end
        if (we) ref_mem[a] = wd;
        else    ref_rd[w] = ref_mem[a];
        @(negedge clk);
        chk("resp_if_valid", bus.if_valid, (w == 0));
        chk("resp_ls_valid", bus.ls_valid, (w == 1));
        chk("resp_if_rdata", bus.if_rdata, ref_rd[0]);
        chk("resp_ls_rdata", bus.ls_rdata, ref_rd[1]);
        chk("resp_mem_en",   bus.mem_en,   0);
        chk("resp_busy",     bus.busy,     1);
        chk("resp_if_gnt",   bus.if_gnt,   0);
        chk("resp_ls_gnt",   bus.ls_gnt,   0);
        n_txn++;
        $display("txn %0d: winner=%s we=%0b addr=%0d wdata=%h if_rdata=%h ls_rdata=%h",
                 n_txn, (w == 1) ? "LS" : "IF", we, a, wd, bus.if_rdata, bus.ls_rdata);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[3] = 32'hDEADBEEF;
        ref_mem[3] = 32'hDEADBEEF;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0;

        // Reset state
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en",   bus.mem_en,   0);
        chk("rst_mem_we",   bus.mem_we,   0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_if_gnt",   bus.if_gnt,   0);
        chk("rst_ls_gnt",   bus.ls_gnt,   0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_ls_valid", bus.ls_valid, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_ls_rdata", bus.ls_rdata, 0);
        rst = 1'b1;

        // IF-only read
        bus.if_req = 1; bus.if_addr = 6'd3;
        do_access(0, 0);
        chk("if_read_deadbeef", bus.if_rdata, 32'hDEADBEEF);
        idle_check();

        // LS store then load it back
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 6'd7; bus.ls_wdata = 32'h12345678;
        do_access(0, 0);
        chk("store_keeps_ls_rdata", bus.ls_rdata, 0);
        idle_check();
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 6'd7;
        do_access(0, 0);
        chk("load_after_store", bus.ls_rdata, 32'h12345678);
        idle_check();

        // Contention, both requesters holding their requests
        bus.if_req = 1; bus.if_addr = 6'd10;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 6'd20;
        repeat (4) do_access(1, 0);
        bus.if_req = 0; bus.ls_req = 0;
        idle_check();

        // LS withdraws a one-cycle request made during an IF access
        bus.if_req = 1; bus.if_addr = 6'd5;
        do_access(0, 1);
        idle_check();

        // Async reset in the second ACCESS cycle
        bus.if_req = 1; bus.if_addr = 6'd9;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_if_gnt", bus.if_gnt, 1);
        bus.if_req = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_mem_en", bus.mem_en, 0);
        chk("async_busy",   bus.busy,   0);
        chk("async_if_gnt", bus.if_gnt, 0);
        chk("async_rdata",  bus.if_rdata, 0);
        repeat (2) begin
            @(negedge clk);
            chk("async_no_if_valid", bus.if_valid, 0);
            chk("async_no_ls_valid", bus.ls_valid, 0);
        end
        rst = 1'b1;
        last = 0;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        bus.if_req = 1; bus.if_addr = 6'd3;
        do_access(0, 0);
        idle_check();

        // Back-to-back IF reads
        for (int i = 0; i < 3; i++) begin
            bus.if_req = 1; bus.if_addr = 6'(i);
            do_access(0, 0);
        end
        idle_check();

        // Random traffic; a losing requester keeps its request pending
        for (int n = 0; n < 40; n++) begin
            if (!bus.if_req && $urandom_range(0, 1) == 1) begin
                bus.if_req = 1; bus.if_addr = 6'($urandom);
            end
            if (!bus.ls_req && $urandom_range(0, 1) == 1) begin
                bus.ls_req = 1; bus.ls_we = 1'($urandom);
                bus.ls_addr = 6'($urandom); bus.ls_wdata = $urandom;
            end
            if (!bus.if_req && !bus.ls_req) begin
                idle_check();
                bus.if_req = 1; bus.if_addr = 6'($urandom);
            end
            do_access(0, 0);
        end
        bus.if_req = 0; bus.ls_req = 0;
        idle_check();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sits between the control unit's fetch/load/store paths and the `veda` memory.
- Serialises accesses, holds address/data stable for a fixed memory latency, and returns read data with a one-cycle valid pulse to the winning requester.

Parameters:
- ADDRESS_WIDTH, 5, memory address MSB index; addresses are [ADDRESS_WIDTH:0].
- DATA_SIZE, 32, memory word width.
- MEM_LATENCY, 1, cycles `mem_en` is held per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDRESS_WIDTH+1  fetch address.
- if_gnt  out  1  one-cycle grant pulse to IF.
- if_valid  out  1  one-cycle read-data-valid pulse to IF.
- if_rdata  out  DATA_SIZE  fetched word.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDRESS_WIDTH+1  load/store address.
- ls_wdata  in  DATA_SIZE  store data.
- ls_gnt  out  1  one-cycle grant pulse to LS.
- ls_valid  out  1  one-cycle completion pulse to LS (load data or store ack).
- ls_rdata  out  DATA_SIZE  loaded word.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDRESS_WIDTH+1  memory address.
- mem_wdata  out  DATA_SIZE  memory write data.
- mem_rdata  in  DATA_SIZE  memory read data; valid in the final mem_en cycle.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; latency counter 0; last-winner = IF.
- FSM states:
  - IDLE: evaluate requests.
  - ACCESS: mem_en=1 for exactly MEM_LATENCY cycles.
  - RESP: one cycle; winner's valid=1; requests are also evaluated in this cycle.
- IDLE/RESP with any request pending:
  - Register the winner; latch addr, we, wdata.
  - Pulse the winner's gnt in the next cycle, the first ACCESS cycle.
  - Load counter with MEM_LATENCY-1.
- IDLE with no request: stay IDLE. RESP with no request: go to IDLE.
- ACCESS:
  - mem_en=1; mem_we=latched we (always 0 for IF); mem_addr/mem_wdata = latched values, stable throughout.
  - Counter decrements each cycle.
  - At counter 0: capture mem_rdata into the winner's rdata register (loads and fetches only), then go to RESP.
- RESP: winner's valid=1 for one cycle. rdata registers hold their value until the next completed read for that requester. A store leaves ls_rdata unchanged.
- Latency: request sampled at cycle N gives gnt at N+1, mem_en N+1..N+MEM_LATENCY, valid at N+MEM_LATENCY+1.
- Back-to-back throughput: one access per MEM_LATENCY+1 cycles.
- Arbitration (default, fixed priority): LS wins over IF on contention.
- Requester contract: req deasserted before gnt withdraws the request, with no access issued. req/addr/data changes after gnt are ignored for the current access.
- gnt is never asserted to both requesters in one cycle; at most one access is in flight.
- Reset asserted mid-ACCESS: access aborted, no valid pulse, mem_en drops immediately (async).
- Simulation-only check: error on MEM_LATENCY==0 or >15.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on contention, grant the requester not granted last. Last-winner updates on every grant. Uncontended requests are unaffected.
- Undefined: fixed priority, LS over IF; last-winner register is not implemented.

Decomposition:
- Package `mem_arb_pkg`:
  - state enum (IDLE, ACCESS, RESP);
  - requester-id enum (REQ_IF=0, REQ_LS=1);
  - MAX_MEM_LATENCY=15 constant.
- Sub-module `arb_picker`: combinational winner select from if_req, ls_req, last-winner and the round-robin macro.
- Counter and FSM stay in the top module.

Test Plan:
- Reset, then IF-only read: if_req=1, if_addr=3, mem returns 0xDEADBEEF (MEM_LATENCY=1) -> if_gnt at cycle 1, mem_en/mem_addr=3 at cycle 1, if_valid with if_rdata=0xDEADBEEF at cycle 2.
- LS store: ls_we=1, ls_addr=7, ls_wdata=0x12345678, MEM_LATENCY=3 -> mem_we=1, mem_addr=7 held 3 cycles, ls_valid at cycle 4, ls_rdata unchanged.
- Contention: if_req and ls_req high at the same cycle, 4 accesses -> fixed mode: LS,LS,LS,LS while LS keeps requesting; RR mode: LS,IF,LS,IF.
- Withdrawal: ls_req pulsed 1 cycle during an IF ACCESS -> no ls_gnt, no store issued, IF completes normally.
- Async reset mid-ACCESS (MEM_LATENCY=3, rst low at 2nd cycle) -> mem_en, busy and gnt go 0 immediately, no valid; after release, a new if_req is served normally.
- Back-to-back IF reads at addrs 0,1,2 with MEM_LATENCY=1 -> if_valid every 2 cycles with the correct data, never both gnt high in one cycle.
